// File: rtl/key_search.sv
// Brute-force ARC4 key search: launches one candidate key at a time, snoops plaintext writes, stops on first all-printable message.
// Latency: LAUNCH + ARC4 run + CHECK per candidate; result registered on the edge leaving CHECK.
// Backpressure: waits on a4_rdy before each launch; en is ignored while a search is in progress.
module key_search #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_END   = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic [23:0] a4_key,
    input  logic        pt_wren,
    input  logic [7:0]  pt_addr,
    input  logic [7:0]  pt_wrdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_q;
    logic        bad_q;
    logic [24:0] key_sum;
    logic        last_key;
    logic        snoop;
    logic        byte_bad;

    // 25-bit sum so a range ending at 24'hFFFFFF terminates instead of wrapping
    assign key_sum  = {1'b0, a4_key} + {1'b0, KEY_STEP};
    assign last_key = key_sum > {1'b0, KEY_END};
    assign snoop    = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign byte_bad = (pt_wrdata < 8'h20) || (pt_wrdata > 8'h7E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a4_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                a4_en = a4_rdy;
                if (a4_rdy) state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!a4_rdy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (a4_rdy) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!bad_q || last_key) state_nxt = S_IDLE;
                else                    state_nxt = S_LAUNCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy       <= 1'b1;
            key       <= 24'h0;
            key_valid <= 1'b0;
            a4_key    <= KEY_START;
            len_q     <= 8'h0;
            bad_q     <= 1'b0;
        end else begin
            rdy <= (state_nxt == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (en) begin
                        key_valid <= 1'b0;
                        a4_key    <= KEY_START;
                    end
                end
                S_LAUNCH: begin
                    len_q <= 8'h0;
                    bad_q <= 1'b0;
                end
                S_CHECK: begin
                    if (!bad_q) begin
                        key       <= a4_key;
                        key_valid <= 1'b1;
                    end else if (!last_key) begin
                        a4_key <= key_sum[23:0];
                    end
                end
                default: ;
            endcase
            // address 0 always arrives first, so len_q is valid for every message byte
            if (snoop && pt_wren) begin
                if (pt_addr == 8'h0) begin
                    len_q <= pt_wrdata;
                end else if ((pt_addr <= len_q) && byte_bad) begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: behavioural ARC4 stand-in, search-level reference model and per-cycle launch checker.
module tb_key_search;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_drv;
    logic        poke;
    logic        poke_flag;
    logic [1:0]  sel;
    int          tmode;
    logic        a4_rdy;
    logic        pt_wren;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_wrdata;

    logic [2:0]  en_v;
    logic [2:0]  rdy_v;
    logic [2:0]  kv_v;
    logic [2:0]  ae_v;
    logic [23:0] key_v [3];
    logic [23:0] ak_v  [3];
    logic [23:0] starts [3] = '{24'h000000, 24'h000010, 24'hFFFFFD};

    assign en_v[0] = (sel == 2'd0) & (en_drv | poke);
    assign en_v[1] = (sel == 2'd1) & (en_drv | poke);
    assign en_v[2] = (sel == 2'd2) & (en_drv | poke);

    logic        m_en, m_rdy, m_kv;
    logic [23:0] m_key, m_keyout;
    assign m_en     = ae_v[sel];
    assign m_rdy    = rdy_v[sel];
    assign m_kv     = kv_v[sel];
    assign m_key    = ak_v[sel];
    assign m_keyout = key_v[sel];

    key_search u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]), .key(key_v[0]),
        .key_valid(kv_v[0]), .a4_en(ae_v[0]), .a4_rdy(a4_rdy), .a4_key(ak_v[0]),
        .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata)
    );

    key_search #(.KEY_START(24'h000010), .KEY_END(24'h000012)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]), .key(key_v[1]),
        .key_valid(kv_v[1]), .a4_en(ae_v[1]), .a4_rdy(a4_rdy), .a4_key(ak_v[1]),
        .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata)
    );

    key_search #(.KEY_START(24'hFFFFFD), .KEY_END(24'hFFFFFF), .KEY_STEP(24'd2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rdy(rdy_v[2]), .key(key_v[2]),
        .key_valid(kv_v[2]), .a4_en(ae_v[2]), .a4_rdy(a4_rdy), .a4_key(ak_v[2]),
        .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Message table: address 0 carries the length, addresses 1..nwr the bytes written
    function automatic int msg_nwr(int mode, logic [23:0] k);
        case (mode)
            0:       return (k == 24'd3) ? 2 : 1;
            2:       return (k == 24'd2) ? 2 : 1;
            4:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(int mode, logic [23:0] k, int a);
        case (mode)
            0: begin
                if (k == 24'd3) return (a == 0) ? 8'd2 : (a == 1) ? 8'h48 : 8'h69;
                return (a == 0) ? 8'd1 : 8'h07;
            end
            2: begin
                if (k == 24'd0) return (a == 0) ? 8'd1 : 8'h1F;
                if (k == 24'd1) return (a == 0) ? 8'd1 : 8'h7F;
                if (k == 24'd2) return (a == 0) ? 8'd2 : (a == 1) ? 8'h20 : 8'h7E;
                return (a == 0) ? 8'd1 : 8'h07;
            end
            3: return (a == 0) ? 8'd0 : 8'h07;
            4: begin
                if (k == 24'd0) return (a == 0) ? 8'd2 : (a == 1) ? 8'h41 : 8'h7F;
                return (a == 0) ? 8'd1 : (a == 1) ? 8'h41 : 8'h00;
            end
            default: return (a == 0) ? 8'd1 : 8'h07;
        endcase
    endfunction

    function automatic bit key_ok(int mode, logic [23:0] k);
        int len;
        logic [7:0] b;
        len = int'(msg_byte(mode, k, 0));
        for (int a = 1; a <= len && a <= msg_nwr(mode, k); a++) begin
            b = msg_byte(mode, k, a);
            if (b < 8'h20 || b > 8'h7E) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic [23:0] exp_q [$];
    int          exp_n;
    bit          exp_found;
    logic [23:0] exp_key;

    task automatic model_search(int mode, logic [23:0] s, logic [23:0] e, logic [23:0] st);
        logic [24:0] k;
        k = {1'b0, s};
        exp_q.delete();
        exp_n = 0;
        exp_found = 1'b0;
        exp_key = 24'h0;
        while (1) begin
            exp_q.push_back(k[23:0]);
            exp_n++;
            if (key_ok(mode, k[23:0])) begin
                exp_found = 1'b1;
                exp_key = k[23:0];
                break;
            end
            if (k + {1'b0, st} > {1'b0, e}) break;
            k = k + {1'b0, st};
        end
    endtask

    // ARC4 stand-in: rdy drops after en, writes length then bytes, then rdy rises
    initial begin
        logic [23:0] k;
        int n;
        a4_rdy = 1'b1; pt_wren = 1'b0; pt_addr = 8'h0; pt_wrdata = 8'h0; poke = 1'b0;
        forever begin
            @(negedge clk);
            if (m_en === 1'b1) begin
                k = m_key;
                n = msg_nwr(tmode, k);
                @(posedge clk); #1 a4_rdy = 1'b0;
                @(posedge clk); #1 pt_wren = 1'b1; pt_addr = 8'h0;
                pt_wrdata = msg_byte(tmode, k, 0); poke = poke_flag;
                for (int a = 1; a <= n; a++) begin
                    @(posedge clk); #1 poke = 1'b0; pt_addr = 8'(a);
                    pt_wrdata = msg_byte(tmode, k, a);
                end
                @(posedge clk); #1 pt_wren = 1'b0; poke = 1'b0; a4_rdy = 1'b1;
            end
        end
    end

    logic        cmp_on = 1'b0;
    logic        prev_en = 1'b0;
    int          launches = 0;
    logic [23:0] last_launch = 24'h0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmp_on) begin
            if (m_en === 1'b1) begin
                launches++;
                last_launch = m_key;
                if (exp_q.size() == 0) chk("launch_extra", launches, exp_n);
                else                   chk("launch_key", m_key, exp_q.pop_front());
                chk("a4_en_while_rdy", m_rdy, 1'b0);
                chk("a4_en_double", prev_en, 1'b0);
            end
            prev_en = m_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic reset_chk(string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_rdy"}, rdy_v[d], 1'b1);
            chk({nm, "_key_valid"}, kv_v[d], 1'b0);
            chk({nm, "_key"}, key_v[d], 24'h0);
            chk({nm, "_a4_en"}, ae_v[d], 1'b0);
            chk({nm, "_a4_key"}, ak_v[d], starts[d]);
        end
    endtask

    task automatic run(logic [1:0] d, int mode, logic [23:0] s, logic [23:0] e, logic [23:0] st,
                       bit pk, int lit_n, bit lit_found, logic [23:0] lit_key,
                       logic [23:0] lit_last, string nm);
        int cyc;
        sel = d; tmode = mode; poke_flag = pk;
        model_search(mode, s, e, st);
        launches = 0;
        @(negedge clk); en_drv = 1'b1;
        @(negedge clk); en_drv = 1'b0;
        chk({nm, "_first_launch"}, m_en, 1'b1);
        cyc = 0;
        while (m_rdy !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, m_rdy, 1'b1);
        chk({nm, "_valid_model"}, m_kv, exp_found);
        chk({nm, "_valid"}, m_kv, lit_found);
        if (lit_found) begin
            chk({nm, "_key_model"}, m_keyout, exp_key);
            chk({nm, "_key"}, m_keyout, lit_key);
        end
        chk({nm, "_launches_model"}, launches, exp_n);
        chk({nm, "_launches"}, launches, lit_n);
        chk({nm, "_last_launch"}, last_launch, lit_last);
        poke_flag = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1; en_drv = 1'b0; sel = 2'd0; tmode = 0; poke_flag = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_chk("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        run(2'd0, 0, 24'h0, 24'hFFFFFF, 24'd1, 1'b0, 4, 1'b1, 24'h3, 24'h3, "find");

        // abort a search in WAIT_DONE, then restart from KEY_START
        sel = 2'd0; tmode = 0;
        model_search(0, 24'h0, 24'hFFFFFF, 24'd1);
        launches = 0;
        @(negedge clk); en_drv = 1'b1;
        @(negedge clk); en_drv = 1'b0;
        cyc = 0;
        while (pt_wren !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reach_wait_done", pt_wren, 1'b1);
        #2 rst_n = 1'b0;
        #1 reset_chk("rst_mid");
        repeat (10) @(negedge clk);
        rst_n = 1'b1;

        run(2'd0, 0, 24'h0, 24'hFFFFFF, 24'd1, 1'b0, 4, 1'b1, 24'h3, 24'h3, "restart");
        run(2'd0, 2, 24'h0, 24'hFFFFFF, 24'd1, 1'b0, 3, 1'b1, 24'h2, 24'h2, "chars");
        run(2'd0, 3, 24'h0, 24'hFFFFFF, 24'd1, 1'b0, 1, 1'b1, 24'h0, 24'h0, "len0");
        run(2'd0, 4, 24'h0, 24'hFFFFFF, 24'd1, 1'b0, 2, 1'b1, 24'h1, 24'h1, "len_edge");
        run(2'd0, 0, 24'h0, 24'hFFFFFF, 24'd1, 1'b1, 4, 1'b1, 24'h3, 24'h3, "busy");
        run(2'd1, 1, 24'h10, 24'h12, 24'd1, 1'b0, 3, 1'b0, 24'h0, 24'h12, "exhaust");
        run(2'd2, 1, 24'hFFFFFD, 24'hFFFFFF, 24'd2, 1'b0, 2, 1'b0, 24'h0, 24'hFFFFFF, "step");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
